// File: rtl/uart_pkt_router_pkg.sv
// Shared types and constants for the UART packet router.
// Holds the router state enum, header constants, error-cause codes and a
// helper that sizes the word-index field.
package uart_pkt_router_pkg;

  typedef enum logic [1:0] {
    HDR        = 2'd0,
    CH_PAY     = 2'd1,
    LAUNCH_PAY = 2'd2
  } state_e;

  localparam logic [31:0] LAUNCH_HDR  = 32'hFFFF_FFFF;
  localparam logic [7:0]  HDR_TAG     = 8'hFF;

  localparam logic [1:0]  ERR_NONE    = 2'd0;
  localparam logic [1:0]  ERR_HDR     = 2'd1;
  localparam logic [1:0]  ERR_TIMEOUT = 2'd2;

  // Width of a word index able to address max(a, b) words, never below 1.
  function automatic int unsigned idx_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/uart_word_asm.sv
// Byte-to-word assembler with byte counter and idle timeout.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_rx_data/valid  incoming byte and its one-cycle strobe
//   i_clear          drop window, byte count and idle count
//   i_armed          idle counter runs only while armed
//   o_word_nxt_c     window including the current byte (MSB first)
//   o_word_c         current byte completes a 4-byte group
//   o_eval_c         current byte gives at least 4 bytes since clear
//   o_partial_c      1..3 bytes held since clear
//   o_timeout_c      this is the last tolerated idle clock
module uart_word_asm
  import uart_pkt_router_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_clear,
  input  logic        i_armed,
  output logic [31:0] o_word_nxt_c,
  output logic        o_word_c,
  output logic        o_eval_c,
  output logic        o_partial_c,
  output logic        o_timeout_c
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [31:0]       win_q;
  logic [1:0]        cnt_q;
  logic              full_q;
  logic [IDLE_W-1:0] idle_q;

  assign o_word_nxt_c = {win_q[23:0], i_rx_data};
  assign o_word_c     = i_rx_valid && (cnt_q == 2'd3);
  assign o_eval_c     = i_rx_valid && (full_q || (cnt_q == 2'd3));
  assign o_partial_c  = !full_q && (cnt_q != 2'd0);
  // A byte in the same cycle suppresses the timeout.
  assign o_timeout_c  = i_armed && !i_rx_valid &&
                        (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

  // Shift window, group counter and idle counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_q  <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      idle_q <= '0;
    end else if (i_clear) begin
      win_q  <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      idle_q <= '0;
    end else if (i_rx_valid) begin
      win_q  <= o_word_nxt_c;
      cnt_q  <= cnt_q + 2'd1;
      if (cnt_q == 2'd3) full_q <= 1'b1;
      idle_q <= '0;
    end else if (i_armed) begin
      idle_q <= idle_q + IDLE_W'(1);
    end else begin
      idle_q <= '0;
    end
  end

endmodule

// File: rtl/uart_pkt_router.sv
// UART packet router: decodes launch/channel headers from a byte stream and
// emits per-word write strobes to DC channels or the launch register.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_rx_data/i_rx_valid  received byte and one-cycle strobe
//   o_word, o_word_idx    assembled payload word and its index
//   o_ch_we               per-channel write strobe (multicast mask)
//   o_launch_we           launch-register write strobe
//   o_pkt_done            pulse with the final word strobe
//   o_err, o_err_code     error pulse and last cause (1 header, 2 timeout)
//   o_err_cnt             saturating error count
module uart_pkt_router
  import uart_pkt_router_pkg::*;
#(
  parameter int unsigned NUM_CHANNEL    = 4,
  parameter int unsigned CH_WORDS       = 8,
  parameter int unsigned LAUNCH_WORDS   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  localparam int unsigned IDX_W = idx_width(CH_WORDS, LAUNCH_WORDS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic [31:0]            o_word,
  output logic [IDX_W-1:0]       o_word_idx,
  output logic [NUM_CHANNEL-1:0] o_ch_we,
  output logic                   o_launch_we,
  output logic                   o_pkt_done,
  output logic                   o_err,
  output logic [1:0]             o_err_code,
  output logic [15:0]            o_err_cnt
);

  // Header bits above the channel field that must all be one.
  localparam logic [31:0] UPPER_MASK = 32'hFFFF_FFFF << (8 + NUM_CHANNEL);

  state_e                 state_q, state_d;
  logic [NUM_CHANNEL-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]       wcnt_q, wcnt_d;

  logic [31:0]            word_d;
  logic [IDX_W-1:0]       idx_d;
  logic [NUM_CHANNEL-1:0] ch_we_d;
  logic                   launch_we_d, done_d, err_d;
  logic [1:0]             err_code_d;
  logic [15:0]            err_cnt_d;

  logic [31:0]            word_nxt_c;
  logic                   word_c, eval_c, partial_c, timeout_c;
  logic                   clear_c, armed_c;
  logic [NUM_CHANNEL-1:0] hdr_mask_c;
  logic                   is_launch_c, is_ch_c, last_word_c;

  uart_word_asm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_asm (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .i_clear      (clear_c),
    .i_armed      (armed_c),
    .o_word_nxt_c (word_nxt_c),
    .o_word_c     (word_c),
    .o_eval_c     (eval_c),
    .o_partial_c  (partial_c),
    .o_timeout_c  (timeout_c)
  );

  // Header decode on the window that includes the current byte.
  assign hdr_mask_c  = ~word_nxt_c[8 +: NUM_CHANNEL];
  assign is_launch_c = (word_nxt_c == LAUNCH_HDR);
  assign is_ch_c     = (word_nxt_c[7:0] == HDR_TAG) && (hdr_mask_c != '0) &&
                       ((word_nxt_c & UPPER_MASK) == UPPER_MASK);
  assign last_word_c = (state_q == LAUNCH_PAY) ? (wcnt_q == IDX_W'(LAUNCH_WORDS - 1))
                                               : (wcnt_q == IDX_W'(CH_WORDS - 1));
  assign armed_c     = (state_q != HDR) || partial_c;

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= HDR;
      mask_q      <= '0;
      wcnt_q      <= '0;
      o_word      <= '0;
      o_word_idx  <= '0;
      o_ch_we     <= '0;
      o_launch_we <= 1'b0;
      o_pkt_done  <= 1'b0;
      o_err       <= 1'b0;
      o_err_code  <= ERR_NONE;
      o_err_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      wcnt_q      <= wcnt_d;
      o_word      <= word_d;
      o_word_idx  <= idx_d;
      o_ch_we     <= ch_we_d;
      o_launch_we <= launch_we_d;
      o_pkt_done  <= done_d;
      o_err       <= err_d;
      o_err_code  <= err_code_d;
      o_err_cnt   <= err_cnt_d;
    end
  end

  // Next state and assembler window clear.
  always_comb begin
    state_d = state_q;
    clear_c = 1'b0;
    case (state_q)
      HDR: begin
        if (timeout_c) begin
          clear_c = 1'b1;
        end else if (eval_c && is_launch_c) begin
          state_d = LAUNCH_PAY;
          clear_c = 1'b1;
        end else if (eval_c && is_ch_c) begin
          state_d = CH_PAY;
          clear_c = 1'b1;
        end
      end
      CH_PAY, LAUNCH_PAY: begin
        if (timeout_c || (word_c && last_word_c)) begin
          state_d = HDR;
          clear_c = 1'b1;
        end
      end
      default: begin
        state_d = HDR;
        clear_c = 1'b1;
      end
    endcase
  end

  // Output, mask and word-counter next values.
  always_comb begin
    word_d      = o_word;
    idx_d       = o_word_idx;
    ch_we_d     = '0;
    launch_we_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = o_err_code;
    err_cnt_d   = o_err_cnt;
    mask_d      = mask_q;
    wcnt_d      = wcnt_q;
    case (state_q)
      HDR: begin
        if (timeout_c) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else if (eval_c) begin
          if (is_launch_c) begin
            wcnt_d = '0;
          end else if (is_ch_c) begin
            wcnt_d = '0;
            mask_d = hdr_mask_c;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_HDR;
          end
        end
      end
      CH_PAY, LAUNCH_PAY: begin
        if (timeout_c) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else if (word_c) begin
          word_d = word_nxt_c;
          idx_d  = wcnt_q;
          if (state_q == CH_PAY) ch_we_d = mask_q;
          else                   launch_we_d = 1'b1;
          wcnt_d = wcnt_q + IDX_W'(1);
          done_d = last_word_c;
        end
      end
      default: ;
    endcase
    if (err_d && (o_err_cnt != 16'hFFFF)) err_cnt_d = o_err_cnt + 16'd1;
  end

endmodule

// File: tb/tb_uart_pkt_router.sv
// Directed self-checking bench for uart_pkt_router (default parameters).
module tb_uart_pkt_router;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] word;
  logic [2:0]  word_idx;
  logic [3:0]  ch_we;
  logic        launch_we, pkt_done, err;
  logic [1:0]  err_code;
  logic [15:0] err_cnt;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  always #5 clk = ~clk;

  uart_pkt_router #(
    .NUM_CHANNEL    (4),
    .CH_WORDS       (8),
    .LAUNCH_WORDS   (4),
    .TIMEOUT_CYCLES (20000)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_word      (word),
    .o_word_idx  (word_idx),
    .o_ch_we     (ch_we),
    .o_launch_we (launch_we),
    .o_pkt_done  (pkt_done),
    .o_err       (err),
    .o_err_code  (err_code),
    .o_err_cnt   (err_cnt)
  );

  // Strobe / error recorder, sampled mid-cycle.
  int          n_wr = 0, n_err = 0, n_done = 0, n_multi = 0;
  logic [31:0] wr_word [256];
  int          wr_idx  [256];
  logic [3:0]  wr_ch   [256];
  logic        wr_l    [256];
  logic        wr_d    [256];

  always @(negedge clk) begin
    if ((ch_we != 4'd0) || launch_we) begin
      if (n_wr < 256) begin
        wr_word[n_wr] = word;
        wr_idx[n_wr]  = 32'(word_idx);
        wr_ch[n_wr]   = ch_we;
        wr_l[n_wr]    = launch_we;
        wr_d[n_wr]    = pkt_done;
      end
      n_wr++;
    end
    if (err) n_err++;
    if (pkt_done) n_done++;
    if (((ch_we != 4'd0) && launch_we) || ((ch_we != 4'd0) && err) || (launch_we && err))
      n_multi++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] exp_w [8];

  task automatic send_pkt(input logic [31:0] hdr, input int nw);
    send_word(hdr);
    for (int k = 0; k < nw; k++) send_word(exp_w[k]);
    idle(3);
  endtask

  task automatic check_pkt(input string tag, input int base, input int nw,
                           input logic [3:0] ch, input logic l);
    chk($sformatf("%s_strobes", tag), 32'(n_wr - base), 32'(nw));
    for (int k = 0; k < nw; k++) begin
      if (base + k < 256) begin
        chk($sformatf("%s_w%0d", tag, k),    wr_word[base+k], exp_w[k]);
        chk($sformatf("%s_idx%0d", tag, k),  32'(wr_idx[base+k]), 32'(k));
        chk($sformatf("%s_ch%0d", tag, k),   32'(wr_ch[base+k]), 32'(ch));
        chk($sformatf("%s_l%0d", tag, k),    32'(wr_l[base+k]), 32'(l));
        chk($sformatf("%s_done%0d", tag, k), 32'(wr_d[base+k]), 32'(k == nw - 1));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_word"},     word, 32'h0);
    chk({tag, "_idx"},      32'(word_idx), 32'h0);
    chk({tag, "_ch_we"},    32'(ch_we), 32'h0);
    chk({tag, "_launch"},   32'(launch_we), 32'h0);
    chk({tag, "_done"},     32'(pkt_done), 32'h0);
    chk({tag, "_err"},      32'(err), 32'h0);
    chk({tag, "_err_code"}, 32'(err_code), 32'h0);
    chk({tag, "_err_cnt"},  32'(err_cnt), 32'h0);
  endtask

  int base, e0, d0, waited;

  initial begin
    // Reset values
    idle(3);
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Unicast channel 0
    for (int k = 0; k < 8; k++) exp_w[k] = {16'(2*k + 1), 16'(2*k + 2)};
    base = n_wr; d0 = n_done;
    send_pkt(32'hFFFF_FEFF, 8);
    check_pkt("ch0", base, 8, 4'b0001, 1'b0);
    chk("ch0_done_cnt", 32'(n_done - d0), 32'd1);
    chk("hold_word", word, 32'h000F_0010);
    chk("hold_idx", 32'(word_idx), 32'd7);

    // Multicast channels 2 and 3
    for (int k = 0; k < 8; k++) exp_w[k] = 32'hA500_0000 + 32'(k);
    base = n_wr;
    send_pkt(32'hFFFF_F3FF, 8);
    check_pkt("mc", base, 8, 4'b1100, 1'b0);

    // Launch packet
    exp_w[0] = 32'h0000_000F; exp_w[1] = 32'h0000_00F0;
    exp_w[2] = 32'h0000_0F00; exp_w[3] = 32'h0000_F000;
    base = n_wr; d0 = n_done;
    send_pkt(32'hFFFF_FFFF, 4);
    check_pkt("launch", base, 4, 4'b0000, 1'b1);
    chk("launch_done_cnt", 32'(n_done - d0), 32'd1);
    chk("no_err_yet", 32'(n_err), 32'd0);
    chk("err_code_none", 32'(err_code), 32'd0);

    // Resync: stray byte then channel 1 header
    for (int k = 0; k < 8; k++) exp_w[k] = 32'h1111_0000 + 32'(k);
    base = n_wr; e0 = n_err;
    send_byte(8'h12);
    send_word(32'hFFFF_FDFF);
    idle(2);
    chk("resync_err_pulses", 32'(n_err - e0), 32'd1);
    chk("resync_err_code", 32'(err_code), 32'd1);
    chk("resync_err_cnt", 32'(err_cnt), 32'd1);
    for (int k = 0; k < 8; k++) send_word(exp_w[k]);
    idle(3);
    check_pkt("ch1", base, 8, 4'b0010, 1'b0);
    chk("ch1_no_new_err", 32'(n_err - e0), 32'd1);

    // Timeout mid-packet after 2.5 words
    base = n_wr; e0 = n_err;
    send_word(32'hFFFF_FEFF);
    send_word(32'hCAFE_0001);
    send_word(32'hCAFE_0002);
    send_byte(8'h55);
    send_byte(8'h66);
    waited = 0;
    while (!err && waited < 20100) begin
      @(negedge clk);
      waited++;
    end
    chk("to_wait_cycles", 32'(waited), 32'd20000);
    chk("to_err_code", 32'(err_code), 32'd2);
    idle(2);
    chk("to_err_pulses", 32'(n_err - e0), 32'd1);
    chk("to_strobes", 32'(n_wr - base), 32'd2);
    chk("to_err_cnt", 32'(err_cnt), 32'd2);
    for (int k = 0; k < 8; k++) exp_w[k] = 32'h7700_0000 + 32'(k);
    base = n_wr;
    send_pkt(32'hFFFF_FEFF, 8);
    check_pkt("after_to", base, 8, 4'b0001, 1'b0);

    // Header with channel bit above NUM_CHANNEL cleared
    base = n_wr; e0 = n_err;
    send_word(32'hFFFF_DFFF);
    idle(3);
    chk("bad_hdr_err_pulses", 32'(n_err - e0), 32'd1);
    chk("bad_hdr_err_code", 32'(err_code), 32'd1);
    chk("bad_hdr_strobes", 32'(n_wr - base), 32'd0);
    chk("bad_hdr_err_cnt", 32'(err_cnt), 32'd3);

    // Reset mid-packet
    send_word(32'hFFFF_FEFF);
    send_word(32'hDEAD_BEEF);
    send_byte(8'h01);
    send_byte(8'h02);
    chk("pre_rst_word", word, 32'hDEAD_BEEF);
    @(negedge clk);
    rst_n = 1'b0;
    base = n_wr; e0 = n_err;
    @(negedge clk);
    check_all_zero("mid_rst");
    idle(2);
    rst_n = 1'b1;
    idle(3);
    chk("post_rst_strobes", 32'(n_wr - base), 32'd0);
    chk("post_rst_err", 32'(n_err - e0), 32'd0);
    exp_w[0] = 32'h0102_0304; exp_w[1] = 32'h0506_0708;
    exp_w[2] = 32'h090A_0B0C; exp_w[3] = 32'h0D0E_0F10;
    base = n_wr;
    send_pkt(32'hFFFF_FFFF, 4);
    check_pkt("post_rst_launch", base, 4, 4'b0000, 1'b1);
    chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);

    chk("exclusive_strobes", 32'(n_multi), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_pkt_router.md
UART_PKT_ROUTER -- requirements
Module: uart_pkt_router

Interface
REQ-001 SHALL have parameter NUM_CHANNEL, default 4, number of DC channels addressable, legal range 1..24.
REQ-002 SHALL have parameter CH_WORDS, default 8, 32-bit payload words per channel packet.
REQ-003 SHALL have parameter LAUNCH_WORDS, default 4, 32-bit payload words per launch packet.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 20000, idle clocks tolerated between bytes inside a packet.
REQ-005 SHALL have ports: i_clk  in  1  clock; i_rst_n  in  1  reset.
REQ-006 SHALL have ports: i_rx_data  in  8  received byte; i_rx_valid  in  1  one-cycle byte strobe.
REQ-007 SHALL have ports: o_word  out  32  assembled payload word; o_word_idx  out  $clog2(max(CH_WORDS,LAUNCH_WORDS))  word index in packet.
REQ-008 SHALL have ports: o_ch_we  out  NUM_CHANNEL  per-channel write strobe; o_launch_we  out  1  launch-register write strobe.
REQ-009 SHALL have ports: o_pkt_done  out  1  packet-complete pulse; o_err  out  1  error pulse; o_err_code  out  2  error cause; o_err_cnt  out  16  error count.
REQ-010 SHALL use one clock, i_clk; reset i_rst_n SHALL be asynchronous and active-low.

Function
REQ-011 SHALL assemble bytes MSB first: first byte of each 4-byte group is bits [31:24].
REQ-012 SHALL implement states HDR, CH_PAY, LAUNCH_PAY.
REQ-013 HDR: 32-bit header shift register; evaluated on every byte once 4 bytes received since entering HDR (sliding window, resync).
REQ-014 Header 0xFFFFFFFF -> LAUNCH_PAY, byte and word counters cleared.
REQ-015 Channel header: bits [7:0]=0xFF, mask m = ~header[8+NUM_CHANNEL-1:8] nonzero, all bits [31:8+NUM_CHANNEL] one -> CH_PAY with latched mask m.
REQ-016 Mask with multiple bits set SHALL be legal (multicast): the same payload is written to every selected channel.
REQ-017 Other evaluated header values SHALL pulse o_err with o_err_code=1 and remain in HDR, window sliding (no reset of shift register).
REQ-018 CH_PAY: on 4th byte of each word, next cycle o_word valid, o_word_idx = word number, o_ch_we = latched mask for exactly one cycle.
REQ-019 LAUNCH_PAY: same timing, o_launch_we pulses instead of o_ch_we.
REQ-020 After the last word (CH_WORDS or LAUNCH_WORDS), o_pkt_done SHALL pulse in the same cycle as the final write strobe; state -> HDR, window cleared.
REQ-021 Timeout: in CH_PAY/LAUNCH_PAY, or in HDR with 1-3 bytes buffered, TIMEOUT_CYCLES clocks without i_rx_valid -> o_err pulse, o_err_code=2, partial word discarded, state -> HDR, window cleared; no write strobe.
REQ-022 Idle counter SHALL reset on each i_rx_valid; timeout and byte arrival in same cycle -> byte wins.
REQ-023 o_err_cnt SHALL increment on every o_err pulse and saturate at 0xFFFF.
REQ-024 o_err_code SHALL hold last error cause until next error; 0 = none since reset.
REQ-025 o_word, o_word_idx SHALL hold their values between strobes.
REQ-026 At most one of o_ch_we (any bit), o_launch_we, o_err SHALL be asserted per cycle.

Reset
REQ-027 On i_rst_n low: state HDR, window and counters cleared, all outputs 0, including o_err_cnt and o_err_code.
REQ-028 Reset mid-packet SHALL abandon the packet with no strobe and no error count.

Structure
REQ-029 Shared package SHALL hold the state enum, header constants (LAUNCH_HDR=0xFFFFFFFF, HDR_TAG=0xFF) and error-code constants.
REQ-030 Sub-module uart_word_asm (byte-to-32-bit assembler with byte counter and idle timeout) is natural; the FSM and header decode stay in the top.

Verification
REQ-031 Header 0xFFFFFEFF + 8 words 0x00010002.. -> o_ch_we=4'b0001 eight times, idx 0..7, words in order, o_pkt_done on 8th.
REQ-032 Header 0xFFFFF3FF + 8 words -> o_ch_we=4'b1100 on each word, no other channel written.
REQ-033 Header 0xFFFFFFFF + 4 words 0x0000000F,... -> o_launch_we four times, idx 0..3, o_pkt_done on 4th.
REQ-034 Bytes 0x12 then 0xFFFFFDFF -> one o_err code 1 (window 0x12FFFFFD), then channel 1 packet accepted normally.
REQ-035 Channel 0 header + 2.5 words then 20000 idle clocks -> o_err code 2, 2 strobes only, o_err_cnt=1; next full packet accepted.
REQ-036 Header 0xFFFFDFFF with NUM_CHANNEL=4 (bit 13 clear) -> o_err code 1, no strobes; assert i_rst_n low mid-packet -> all outputs 0, o_err_cnt=0.
